// File: rtl/spm_bank_ctrl.sv
// spm_bank_ctrl: scratchpad bank controller that maps an axi_to_mem bank port onto NumRows stacked
// SRAM macros and zero-fills them after reset. Optional macro SPM_BANK_OUT_REG_EN registers the response.
module spm_bank_ctrl #(
  parameter int DataWidth   = 64,
  parameter int WordsPerRow = 1024,
  parameter int NumRows     = 1,
  parameter int AddrWidth   = 18
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               mem_req_i,
  output logic                               mem_gnt_o,
  input  logic                               mem_we_i,
  input  logic [AddrWidth-1:0]               mem_addr_i,
  input  logic [DataWidth-1:0]               mem_wdata_i,
  input  logic [DataWidth/8-1:0]             mem_strb_i,
  output logic                               mem_rvalid_o,
  output logic [DataWidth-1:0]               mem_rdata_o,
  output logic [NumRows-1:0]                 sram_req_o,
  output logic                               sram_we_o,
  output logic [$clog2(WordsPerRow)-1:0]     sram_addr_o,
  output logic [DataWidth-1:0]               sram_wdata_o,
  output logic [DataWidth/8-1:0]             sram_be_o,
  input  logic [NumRows-1:0][DataWidth-1:0]  sram_rdata_i,
  output logic                               init_done_o,
  output logic                               addr_err_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int ByteOffW  = $clog2(StrbWidth);
  localparam int WordW     = $clog2(WordsPerRow);
  localparam int RowSelW   = (NumRows > 1) ? $clog2(NumRows) : 0;
  localparam int RowW      = (NumRows > 1) ? $clog2(NumRows) : 1;

  localparam logic [WordW-1:0] LastWord   = WordW'(WordsPerRow - 1);
  localparam logic [RowW:0]    NumRowsCmp = (RowW + 1)'(NumRows);

  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]           state_q;
  logic [WordW-1:0]     init_cnt_q;
  logic [WordW-1:0]     word_idx;
  logic [RowW-1:0]      row_idx;
  logic                 row_ok;
  logic                 accept;
  logic                 rsp_valid_q;
  logic                 rsp_we_q;
  logic                 rsp_err_q;
  logic [RowW-1:0]      rsp_row_q;
  logic [DataWidth-1:0] row_rdata;
  logic [DataWidth-1:0] rsp_data;
  logic                 unused_addr_bits;

  assign word_idx         = mem_addr_i[ByteOffW +: WordW];
  assign unused_addr_bits = ^mem_addr_i;

  generate
    if (NumRows > 1) begin : g_multi_row
      assign row_idx = mem_addr_i[ByteOffW + WordW +: RowSelW];
    end else begin : g_single_row
      assign row_idx = '0;
    end
  endgenerate

  // Zero-fill sweeps every word once, then the bank stays READY until the next reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else if (state_q == INIT) begin
      if (init_cnt_q == LastWord) begin
        state_q    <= READY;
        init_cnt_q <= '0;
      end else begin
        init_cnt_q <= init_cnt_q + 1'b1;
      end
    end
  end

  assign mem_gnt_o   = (state_q == READY);
  assign init_done_o = (state_q == READY);
  assign accept      = mem_req_i & mem_gnt_o;
  assign row_ok      = ({1'b0, row_idx} < NumRowsCmp);
  assign addr_err_o  = accept & ~row_ok;

  always_comb begin
    sram_req_o   = '0;
    sram_we_o    = mem_we_i;
    sram_addr_o  = word_idx;
    sram_wdata_o = mem_wdata_i;
    sram_be_o    = mem_strb_i;
    if (state_q == INIT) begin
      sram_req_o   = '1;
      sram_we_o    = 1'b1;
      sram_addr_o  = init_cnt_q;
      sram_wdata_o = '0;
      sram_be_o    = '1;
    end else if (accept && row_ok) begin
      for (int r = 0; r < NumRows; r++) begin
        sram_req_o[r] = (row_idx == RowW'(r));
      end
    end
  end

  // Remember what was issued so the one-cycle SRAM read data can be steered and masked.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_row_q   <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_we_q  <= mem_we_i;
        rsp_err_q <= ~row_ok;
        rsp_row_q <= row_idx;
      end
    end
  end

  always_comb begin
    row_rdata = '0;
    for (int r = 0; r < NumRows; r++) begin
      if (rsp_row_q == RowW'(r)) begin
        row_rdata = sram_rdata_i[r];
      end
    end
  end

  assign rsp_data = (rsp_valid_q && !rsp_we_q && !rsp_err_q) ? row_rdata : '0;

`ifdef SPM_BANK_OUT_REG_EN
  logic                 out_valid_q;
  logic [DataWidth-1:0] out_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= rsp_valid_q;
      out_data_q  <= rsp_data;
    end
  end

  assign mem_rvalid_o = out_valid_q;
  assign mem_rdata_o  = out_data_q;
`else
  assign mem_rvalid_o = rsp_valid_q;
  assign mem_rdata_o  = rsp_data;
`endif

endmodule

// File: tb/tb_spm_bank_ctrl.sv
// tb_spm_bank_ctrl: directed bench for spm_bank_ctrl with two instances (2 and 3 rows, 16 words each)
// backed by behavioural one-cycle SRAM macros.
module tb_spm_bank_ctrl;

  localparam int DW  = 64;
  localparam int WPR = 16;
  localparam int AW  = 18;
  localparam int BW  = 8;
  localparam int WW  = 4;
`ifdef SPM_BANK_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  req2, we2, gnt2, rvalid2, done2, err2, swe2;
  logic [AW-1:0]         addr2;
  logic [DW-1:0]         wdata2, rdata2, swdata2;
  logic [BW-1:0]         strb2, sbe2;
  logic [1:0]            sreq2;
  logic [WW-1:0]         saddr2;
  logic [1:0][DW-1:0]    srdata2;
  logic [DW-1:0]         mem2 [2][WPR];

  logic                  req3, we3, gnt3, rvalid3, done3, err3, swe3;
  logic [AW-1:0]         addr3;
  logic [DW-1:0]         wdata3, rdata3, swdata3;
  logic [BW-1:0]         strb3, sbe3;
  logic [2:0]            sreq3;
  logic [WW-1:0]         saddr3;
  logic [2:0][DW-1:0]    srdata3;
  logic [DW-1:0]         mem3 [3][WPR];

  spm_bank_ctrl #(.DataWidth(DW), .WordsPerRow(WPR), .NumRows(2), .AddrWidth(AW)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req2), .mem_gnt_o(gnt2), .mem_we_i(we2),
    .mem_addr_i(addr2), .mem_wdata_i(wdata2), .mem_strb_i(strb2), .mem_rvalid_o(rvalid2),
    .mem_rdata_o(rdata2), .sram_req_o(sreq2), .sram_we_o(swe2), .sram_addr_o(saddr2),
    .sram_wdata_o(swdata2), .sram_be_o(sbe2), .sram_rdata_i(srdata2), .init_done_o(done2),
    .addr_err_o(err2)
  );

  spm_bank_ctrl #(.DataWidth(DW), .WordsPerRow(WPR), .NumRows(3), .AddrWidth(AW)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req3), .mem_gnt_o(gnt3), .mem_we_i(we3),
    .mem_addr_i(addr3), .mem_wdata_i(wdata3), .mem_strb_i(strb3), .mem_rvalid_o(rvalid3),
    .mem_rdata_o(rdata3), .sram_req_o(sreq3), .sram_we_o(swe3), .sram_addr_o(saddr3),
    .sram_wdata_o(swdata3), .sram_be_o(sbe3), .sram_rdata_i(srdata3), .init_done_o(done3),
    .addr_err_o(err3)
  );

  // Behavioural macros: byte-enabled writes, registered reads.
  always @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (sreq2[r]) begin
        if (swe2) begin
          for (int b = 0; b < BW; b++) if (sbe2[b]) mem2[r][saddr2][b*8 +: 8] <= swdata2[b*8 +: 8];
        end else begin
          srdata2[r] <= mem2[r][saddr2];
        end
      end
    end
    for (int r = 0; r < 3; r++) begin
      if (sreq3[r]) begin
        if (swe3) begin
          for (int b = 0; b < BW; b++) if (sbe3[b]) mem3[r][saddr3][b*8 +: 8] <= swdata3[b*8 +: 8];
        end else begin
          srdata3[r] <= mem3[r][saddr3];
        end
      end
    end
  end

  function automatic logic [AW-1:0] addr_of(input int row, input int word);
    return AW'(row * 128 + word * 8);
  endfunction

  task automatic idle_inputs();
    req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0; strb2 = '0;
    req3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0; strb3 = '0;
  endtask

  task automatic test_reset();
    int bad;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    compared++;
    if (gnt2 !== 1'b0 || done2 !== 1'b0 || rvalid2 !== 1'b0 || err2 !== 1'b0 || sreq2 !== 2'b11 || saddr2 !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: gnt=%b done=%b rvalid=%b err=%b sram_req=%b addr=%0d, required 0 0 0 0 11 0",
               gnt2, done2, rvalid2, err2, sreq2, saddr2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < WPR; i++) begin
      #1;
      compared++;
      if (gnt2 !== 1'b0 || gnt3 !== 1'b0 || done2 !== 1'b0 || sreq2 !== 2'b11 || sreq3 !== 3'b111 ||
          swe2 !== 1'b1 || sbe2 !== 8'hFF || swdata2 !== 64'd0 || saddr2 !== WW'(i) || saddr3 !== WW'(i)) begin
        mismatched++;
        $display("[TB] FAIL init_cycle_%0d: gnt=%b sram_req=%b/%b we=%b be=%h wdata=%h addr=%0d/%0d, required 0 11/111 1 ff 0 %0d",
                 i, gnt2, sreq2, sreq3, swe2, sbe2, swdata2, saddr2, saddr3, i);
      end
      @(negedge clk);
    end
    #1;
    compared++;
    if (gnt2 !== 1'b1 || done2 !== 1'b1 || gnt3 !== 1'b1 || done3 !== 1'b1 || sreq2 !== 2'b00 || sreq3 !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL init_done: gnt=%b/%b done=%b/%b sram_req=%b/%b, required 1/1 1/1 00/000",
               gnt2, gnt3, done2, done3, sreq2, sreq3);
    end
    bad = 0;
    for (int w = 0; w < WPR; w++) begin
      for (int r = 0; r < 2; r++) if (mem2[r][w] !== 64'd0) bad++;
      for (int r = 0; r < 3; r++) if (mem3[r][w] !== 64'd0) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("[TB] FAIL init_zero: %0d nonzero words, required 0", bad);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp_d;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      req2 = (k < 2); we2 = (k == 0); addr2 = addr_of(1, 5);
      wdata2 = 64'hDEADBEEF_CAFEF00D; strb2 = 8'hFF;
      #1;
      if (k < 2) begin
        compared++;
        if (gnt2 !== 1'b1 || sreq2 !== 2'b10 || err2 !== 1'b0 || saddr2 !== 4'd5 || swe2 !== (k == 0) ||
            swdata2 !== 64'hDEADBEEF_CAFEF00D || sbe2 !== 8'hFF) begin
          mismatched++;
          $display("[TB] FAIL wr_rd_issue_%0d: gnt=%b sram_req=%b err=%b addr=%0d we=%b wdata=%h be=%h, required 1 10 0 5 %0d deadbeefcafef00d ff",
                   k, gnt2, sreq2, err2, saddr2, swe2, swdata2, sbe2, (k == 0));
        end
      end
      exp_d = (k == LAT + 1) ? 64'hDEADBEEF_CAFEF00D : 64'd0;
      compared++;
      if (rvalid2 !== (k >= LAT && k < LAT + 2) || ((k >= LAT && k < LAT + 2) && rdata2 !== exp_d)) begin
        mismatched++;
        $display("[TB] FAIL wr_rd_rsp_%0d: rvalid=%b rdata=%h, required %b %h", k, rvalid2, rdata2,
                 (k >= LAT && k < LAT + 2), exp_d);
      end
    end
    idle_inputs();
  endtask

  task automatic test_partial_write();
    logic [DW-1:0] exp_d;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      req2 = (k < 2); we2 = (k == 0); addr2 = addr_of(0, 3);
      wdata2 = 64'h11111111_22222222; strb2 = 8'h0F;
      #1;
      if (k == 0) begin
        compared++;
        if (sreq2 !== 2'b01 || sbe2 !== 8'h0F) begin
          mismatched++;
          $display("[TB] FAIL partial_issue: sram_req=%b be=%h, required 01 0f", sreq2, sbe2);
        end
      end
      exp_d = (k == LAT + 1) ? 64'h00000000_22222222 : 64'd0;
      compared++;
      if (rvalid2 !== (k >= LAT && k < LAT + 2) || ((k >= LAT && k < LAT + 2) && rdata2 !== exp_d)) begin
        mismatched++;
        $display("[TB] FAIL partial_rsp_%0d: rvalid=%b rdata=%h, required %b %h", k, rvalid2, rdata2,
                 (k >= LAT && k < LAT + 2), exp_d);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int            rows [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int            words[8] = '{1, 1, 2, 2, 1, 1, 2, 2};
    logic [DW-1:0] vals [4] = '{64'h0A0A0A0A_00000001, 64'h1B1B1B1B_00000002,
                                64'h0C0C0C0C_00000003, 64'h1D1D1D1D_00000004};
    logic [DW-1:0] exp_d;
    logic [1:0]    exp_req;
    int            j;
    for (int k = 0; k < 8 + LAT + 1; k++) begin
      @(negedge clk);
      if (k < 8) begin
        req2 = 1'b1; we2 = (k < 4); addr2 = addr_of(rows[k], words[k]);
        wdata2 = vals[k % 4]; strb2 = 8'hFF;
      end else begin
        idle_inputs();
      end
      #1;
      if (k < 8) begin
        exp_req = (rows[k] == 1) ? 2'b10 : 2'b01;
        compared++;
        if (sreq2 !== exp_req || saddr2 !== WW'(words[k])) begin
          mismatched++;
          $display("[TB] FAIL b2b_issue_%0d: sram_req=%b addr=%0d, required %b %0d", k, sreq2, saddr2, exp_req, words[k]);
        end
      end
      j = k - LAT;
      exp_d = (j >= 4 && j < 8) ? vals[j - 4] : 64'd0;
      compared++;
      if (rvalid2 !== (j >= 0 && j < 8) || ((j >= 0 && j < 8) && rdata2 !== exp_d)) begin
        mismatched++;
        $display("[TB] FAIL b2b_rsp_%0d: rvalid=%b rdata=%h, required %b %h", k, rvalid2, rdata2, (j >= 0 && j < 8), exp_d);
      end
    end
  endtask

  task automatic test_out_of_range();
    int            rows[3] = '{2, 3, 2};
    logic [2:0]    exp_req[3] = '{3'b100, 3'b000, 3'b100};
    logic [DW-1:0] exp_d;
    int            pulses = 0;
    int            j;
    for (int k = 0; k < 3 + LAT + 1; k++) begin
      @(negedge clk);
      if (k < 3) begin
        req3 = 1'b1; we3 = (k == 0); addr3 = addr_of(rows[k], 2);
        wdata3 = 64'h01234567_89ABCDEF; strb3 = 8'hFF;
      end else begin
        idle_inputs();
      end
      #1;
      if (err3 === 1'b1) pulses++;
      if (k < 3) begin
        compared++;
        if (gnt3 !== 1'b1 || sreq3 !== exp_req[k] || err3 !== (k == 1)) begin
          mismatched++;
          $display("[TB] FAIL oor_issue_%0d: gnt=%b sram_req=%b err=%b, required 1 %b %b", k, gnt3, sreq3, err3, exp_req[k], (k == 1));
        end
      end
      j = k - LAT;
      exp_d = (j == 2) ? 64'h01234567_89ABCDEF : 64'd0;
      compared++;
      if (rvalid3 !== (j >= 0 && j < 3) || ((j >= 0 && j < 3) && rdata3 !== exp_d)) begin
        mismatched++;
        $display("[TB] FAIL oor_rsp_%0d: rvalid=%b rdata=%h, required %b %h", k, rvalid3, rdata3, (j >= 0 && j < 3), exp_d);
      end
    end
    compared++;
    if (pulses != 1) begin
      mismatched++;
      $display("[TB] FAIL oor_err_pulses: %0d pulses, required 1", pulses);
    end
  endtask

  task automatic test_reset_mid_init();
    logic [DW-1:0] exp_d;
    @(negedge clk);
    idle_inputs();
    req2 = 1'b1; we2 = 1'b0; addr2 = addr_of(1, 5); rst_n = 1'b0;
    #1;
    compared++;
    if (gnt2 !== 1'b1 || sreq2 !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL rst_kill_issue: gnt=%b sram_req=%b, required 1 10", gnt2, sreq2);
    end
    @(negedge clk);
    req2 = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      compared++;
      if (rvalid2 !== 1'b0 || gnt2 !== 1'b0 || saddr2 !== WW'(i)) begin
        mismatched++;
        $display("[TB] FAIL first_init_%0d: rvalid=%b gnt=%b addr=%0d, required 0 0 %0d", i, rvalid2, gnt2, saddr2, i);
      end
      if (i < 7) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req2 = 1'b1; we2 = 1'b1; addr2 = addr_of(1, 9); wdata2 = 64'h5A5A5A5A_C3C3C3C3; strb2 = 8'hFF;
    for (int i = 0; i < WPR; i++) begin
      #1;
      compared++;
      if (rvalid2 !== 1'b0 || gnt2 !== 1'b0 || sreq2 !== 2'b11 || saddr2 !== WW'(i)) begin
        mismatched++;
        $display("[TB] FAIL reinit_%0d: rvalid=%b gnt=%b sram_req=%b addr=%0d, required 0 0 11 %0d", i, rvalid2, gnt2, sreq2, saddr2, i);
      end
      @(negedge clk);
    end
    for (int k = 0; k < LAT + 3; k++) begin
      if (k == 1) begin
        we2 = 1'b0;
      end else if (k == 2) begin
        idle_inputs();
      end
      #1;
      if (k == 0) begin
        compared++;
        if (gnt2 !== 1'b1 || sreq2 !== 2'b10 || saddr2 !== 4'd9 || swe2 !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL held_req_accept: gnt=%b sram_req=%b addr=%0d we=%b, required 1 10 9 1", gnt2, sreq2, saddr2, swe2);
        end
      end
      exp_d = (k == LAT + 1) ? 64'h5A5A5A5A_C3C3C3C3 : 64'd0;
      compared++;
      if (rvalid2 !== (k >= LAT && k < LAT + 2) || ((k >= LAT && k < LAT + 2) && rdata2 !== exp_d)) begin
        mismatched++;
        $display("[TB] FAIL held_req_rsp_%0d: rvalid=%b rdata=%h, required %b %h", k, rvalid2, rdata2,
                 (k >= LAT && k < LAT + 2), exp_d);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int w = 0; w < WPR; w++) begin
      for (int r = 0; r < 2; r++) mem2[r][w] <= 64'hA5A5_0000_0000_0000 | DW'(r * 256 + w);
      for (int r = 0; r < 3; r++) mem3[r][w] <= 64'hC3C3_0000_0000_0000 | DW'(r * 256 + w);
    end
    idle_inputs();
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exceeded 100000, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
